// File: rtl/eth_rx_pkg.sv
// Shared definitions for the GMII receive frame engine.
// Contents: FSM state enum, preamble/SFD bytes, CRC-32 constants, broadcast MAC.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StData,
    StDrop
  } rx_state_e;

  localparam logic [7:0]  PreambleByte = 8'h55;
  localparam logic [7:0]  SfdByte      = 8'hD5;

  // Reflected Ethernet polynomial, LSB-first processing.
  localparam logic [31:0] CrcPoly      = 32'hEDB88320;
  localparam logic [31:0] CrcInit      = 32'hFFFF_FFFF;
  // Register value after running a frame plus its own FCS through the CRC.
  localparam logic [31:0] CrcResidue   = 32'hDEBB_20E3;

  localparam logic [47:0] BcastMac     = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide CRC-32 next-state function (reflected, LSB first).
// Ports:
//   crc_in  - current CRC register value
//   data    - byte to absorb
//   crc_out - CRC register value after absorbing data
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = {1'b0, c[31:1]} ^ CrcPoly;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_frame.sv
// GMII receive frame engine. Strips preamble/SFD, filters on destination MAC,
// checks and strips the FCS, and emits a framed byte stream plus statistics.
// Ports:
//   gmii_rx_clk, rst       - clock and synchronous active-high reset
//   gmii_rx_dv, gmii_rxd   - GMII receive data valid / data
//   rx_data, rx_valid      - frame byte (DA..end of payload) and its strobe
//   rx_sof, rx_eof         - first / last byte markers (with rx_valid)
//   rx_err, rx_len         - bad-frame flag and length excl. FCS (with rx_eof)
//   frame_ok_cnt           - good frames delivered (wraps)
//   frame_err_cnt          - bad frames, runts and preamble errors (wraps)
module gmii_rx_frame
  import eth_rx_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55,
  parameter int unsigned MIN_LEN   = 64,
  parameter int unsigned MAX_LEN   = 1518
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_err,
  output logic [10:0] rx_len,
  output logic [15:0] frame_ok_cnt,
  output logic [15:0] frame_err_cnt
);

  localparam logic [10:0] MinLen = 11'(MIN_LEN);
  localparam logic [10:0] MaxLen = 11'(MAX_LEN);
  localparam logic [10:0] CntMax = 11'h7FF;

  rx_state_e state_q, state_d;

  // Set by reset; holds off new frames until dv has been seen low.
  logic wait_q, wait_d;

  logic [10:0]     cnt_q, cnt_d;
  // [4] is the oldest byte: the next one to emit. [3:0] cover the FCS lag.
  logic [4:0][7:0] dl_q, dl_d;
  logic [31:0]     crc_q, crc_d, crc_next;

  logic [47:0] da;
  logic        da_match;

  logic [7:0]  rx_data_d;
  logic        rx_valid_d, rx_sof_d, rx_eof_d, rx_err_d;
  logic [10:0] rx_len_d;
  logic [15:0] ok_cnt_d, err_cnt_d;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (gmii_rxd),
    .crc_out (crc_next)
  );

  // Only meaningful when byte index 5 is arriving: bytes 0-4 sit in the delay line.
  assign da       = {dl_q, gmii_rxd};
  assign da_match = (da == LOCAL_MAC) || (da == BcastMac);

  // State register and datapath registers.
  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      state_q       <= StIdle;
      wait_q        <= 1'b1;
      cnt_q         <= '0;
      dl_q          <= '0;
      crc_q         <= CrcInit;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_sof        <= 1'b0;
      rx_eof        <= 1'b0;
      rx_err        <= 1'b0;
      rx_len        <= '0;
      frame_ok_cnt  <= '0;
      frame_err_cnt <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      cnt_q         <= cnt_d;
      dl_q          <= dl_d;
      crc_q         <= crc_d;
      rx_data       <= rx_data_d;
      rx_valid      <= rx_valid_d;
      rx_sof        <= rx_sof_d;
      rx_eof        <= rx_eof_d;
      rx_err        <= rx_err_d;
      rx_len        <= rx_len_d;
      frame_ok_cnt  <= ok_cnt_d;
      frame_err_cnt <= err_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q & gmii_rx_dv;
    case (state_q)
      StIdle: begin
        if (gmii_rx_dv && !wait_q) begin
          state_d = (gmii_rxd == PreambleByte) ? StPreamble : StDrop;
        end
      end
      StPreamble: begin
        if (!gmii_rx_dv) begin
          state_d = StIdle;
        end else if (gmii_rxd == SfdByte) begin
          state_d = StData;
        end else if (gmii_rxd != PreambleByte) begin
          state_d = StDrop;
        end
      end
      StData: begin
        if (!gmii_rx_dv) begin
          state_d = StIdle;
        end else if (cnt_q == 11'd5 && !da_match) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (!gmii_rx_dv) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: byte counter, delay line, CRC.
  always_comb begin
    cnt_d = cnt_q;
    dl_d  = dl_q;
    crc_d = crc_q;
    if (state_q == StPreamble && gmii_rx_dv && gmii_rxd == SfdByte) begin
      cnt_d = '0;
      crc_d = CrcInit;
    end else if (state_q == StData && gmii_rx_dv) begin
      dl_d  = {dl_q[3:0], gmii_rxd};
      crc_d = crc_next;
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 11'd1;
    end
  end

  // Output logic; results are registered above.
  always_comb begin
    rx_data_d  = '0;
    rx_valid_d = 1'b0;
    rx_sof_d   = 1'b0;
    rx_eof_d   = 1'b0;
    rx_err_d   = 1'b0;
    rx_len_d   = '0;
    ok_cnt_d   = frame_ok_cnt;
    err_cnt_d  = frame_err_cnt;
    case (state_q)
      StPreamble: begin
        if (gmii_rx_dv && gmii_rxd != PreambleByte && gmii_rxd != SfdByte) begin
          err_cnt_d = frame_err_cnt + 16'd1;
        end
      end
      StData: begin
        if (gmii_rx_dv) begin
          // Byte index 5 arriving releases byte 0, provided the DA passed.
          if (cnt_q > 11'd5 || (cnt_q == 11'd5 && da_match)) begin
            rx_valid_d = 1'b1;
            rx_data_d  = dl_q[4];
            rx_sof_d   = (cnt_q == 11'd5);
          end
        end else if (cnt_q >= 11'd6) begin
          // Reaching here with >= 6 bytes means the DA was accepted.
          rx_valid_d = 1'b1;
          rx_data_d  = dl_q[4];
          rx_eof_d   = 1'b1;
          rx_len_d   = cnt_q - 11'd4;
          rx_err_d   = (crc_q != CrcResidue) || (cnt_q < MinLen) || (cnt_q > MaxLen);
          if (rx_err_d) begin
            err_cnt_d = frame_err_cnt + 16'd1;
          end else begin
            ok_cnt_d = frame_ok_cnt + 16'd1;
          end
        end else begin
          err_cnt_d = frame_err_cnt + 16'd1;
        end
      end
      default: ;
    endcase
  end

endmodule
